// File: rtl/gpu_pkg.sv
// Shared widths and FSM encoding for the line rasteriser.
package gpu_pkg;
    localparam int COORD_W = 8;
    localparam int ERR_W   = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_PLOT  = 3'd2,
        S_DONE  = 3'd3,
        S_REARM = 3'd4
    } state_t;
endpackage

// File: rtl/bresenham_step.sv
// One Bresenham error/step decision; purely combinational, no backpressure.
module bresenham_step
    import gpu_pkg::*;
(
    input  logic signed [ERR_W-1:0]   err_i,
    input  logic        [COORD_W:0]   dx_i,
    input  logic signed [ERR_W-2:0]   dy_i,
    output logic signed [ERR_W-1:0]   err_next_o,
    output logic                      step_x_o,
    output logic                      step_y_o
);
    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_ext;
    logic signed [ERR_W:0] dy_ext;

    always_comb begin
        e2     = {err_i, 1'b0};
        dx_ext = {3'b000, dx_i};
        dy_ext = {{2{dy_i[ERR_W-2]}}, dy_i};
        step_x_o = (e2 >= dy_ext);
        step_y_o = (e2 <= dx_ext);
        err_next_o = err_i;
        if (step_x_o) err_next_o = err_next_o + {dy_i[ERR_W-2], dy_i};
        if (step_y_o) err_next_o = err_next_o + {2'b00, dx_i};
    end
endmodule

// File: rtl/bresenham_line_drawer.sv
// Line rasteriser: first pixel write 2 cycles after draw_en is taken, one pixel per cycle after that.
// mem_ready low holds the current pixel and error term; draw_en must drop before another line is accepted.
module bresenham_line_drawer
    import gpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               mem_ready,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_we,
    output logic               draw_done,
    output logic               busy
);
    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0]        cur_x_q, cur_y_q;
    logic [COORD_W:0]          dx_q;
    logic signed [ERR_W-2:0]   dy_q;
    logic signed [ERR_W-1:0]   err_q, err_step;
    logic                      sx_neg_q, sy_neg_q;
    logic                      step_x, step_y, at_end;
    logic [COORD_W-1:0]        abs_dx, abs_dy;

    assign abs_dx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign abs_dy = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    bresenham_step u_step (
        .err_i      (err_q),
        .dx_i       (dx_q),
        .dy_i       (dy_q),
        .err_next_o (err_step),
        .step_x_o   (step_x),
        .step_y_o   (step_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (draw_en) state_d = S_INIT;
            S_INIT:  state_d = S_PLOT;
            S_PLOT:  if (mem_ready && at_end) state_d = S_DONE;
            S_DONE:  state_d = S_REARM;
            S_REARM: if (!draw_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (draw_en) begin
                    x0_q <= x0;
                    y0_q <= y0;
                    x1_q <= x1;
                    y1_q <= y1;
                end
                S_INIT: begin
                    dx_q     <= {1'b0, abs_dx};
                    dy_q     <= -$signed({2'b00, abs_dy});
                    err_q    <= $signed({3'b000, abs_dx}) - $signed({3'b000, abs_dy});
                    sx_neg_q <= (x1_q < x0_q);
                    sy_neg_q <= (y1_q < y0_q);
                    cur_x_q  <= x0_q;
                    cur_y_q  <= y0_q;
                end
                // A stalled write keeps cur and err frozen; stepping stops at the endpoint so nothing wraps.
                S_PLOT: if (mem_ready && !at_end) begin
                    err_q <= err_step;
                    if (step_x) cur_x_q <= sx_neg_q ? cur_x_q - COORD_W'(1) : cur_x_q + COORD_W'(1);
                    if (step_y) cur_y_q <= sy_neg_q ? cur_y_q - COORD_W'(1) : cur_y_q + COORD_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pixel_we  = (state_q == S_PLOT);
    assign pixel_x   = pixel_we ? cur_x_q : '0;
    assign pixel_y   = pixel_we ? cur_y_q : '0;
    assign draw_done = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Scoreboard bench: the driver queues reference pixels per line, a negedge monitor pops and compares accepted writes.
module tb_bresenham_line_drawer;
    logic       clk = 1'b0;
    logic       rst;
    logic       draw_en;
    logic [7:0] x0, y0, x1, y1;
    logic       mem_ready = 1'b1;
    logic [7:0] pixel_x, pixel_y;
    logic       pixel_we, draw_done, busy;

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    int done_pending = 0;
    int writes_seen  = 0;
    int hold11       = 0;
    int ready_mode   = 0;
    int stall_cnt    = 0;
    int checks       = 0;
    int errors       = 0;

    always #5 clk = ~clk;

    bresenham_line_drawer dut (
        .clk       (clk),
        .rst       (rst),
        .draw_en   (draw_en),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .mem_ready (mem_ready),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .pixel_we  (pixel_we),
        .draw_done (draw_done),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Reference rasteriser on plain integers; appends the expected pixel list to the scoreboard.
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        x  = ax0;
        y  = ay0;
        dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = -((ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1);
        sx = (ax1 >= ax0) ? 1 : -1;
        sy = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy;
        for (int k = 0; k < 600; k++) begin
            exp_q.push_back({8'(x), 8'(y)});
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // mem_ready pattern: 0 always ready, 1 random, 2 stall three cycles on pixel (1,1).
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (pixel_we && pixel_x == 8'd1 && pixel_y == 8'd1 && stall_cnt < 3) begin
                    mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_we) begin
                if (pixel_x == 8'd1 && pixel_y == 8'd1) hold11++;
                if (mem_ready) begin
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got (%0d,%0d) required none", pixel_x, pixel_y);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pixel", {pixel_x, pixel_y}, {16'h0, mon_e});
                    end
                end
            end else begin
                chk("pixel_zero_when_idle", {pixel_x, pixel_y}, 0);
            end
            if (draw_done) begin
                chk("done_we_low", pixel_we, 0);
                chk("done_after_last_pixel", exp_q.size(), 0);
                if (done_pending == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got pulse required none");
                end else begin
                    done_pending--;
                end
            end
        end
    end

    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int mode, input bit check_lat, input int hold);
        int n, edges, adx, ady;
        bit seen;
        adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
        n = ((adx > ady) ? adx : ady) + 1;
        model(ax0, ay0, ax1, ay1);
        done_pending++;
        writes_seen = 0;
        hold11      = 0;
        stall_cnt   = 0;
        ready_mode  = mode;
        @(posedge clk); #1;
        x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
        draw_en = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        // Endpoints are latched by now; changing them must not disturb the line.
        x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
        if (check_lat) begin
            chk("lat_init_no_we", pixel_we, 0);
            chk("lat_init_busy", busy, 1);
            @(posedge clk); #1;
            edges++;
            chk("lat_first_we", pixel_we, 1);
            chk("lat_first_pixel", {pixel_x, pixel_y}, {16'h0, 8'(ax0), 8'(ay0)});
        end
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (draw_done) seen = 1'b1;
        end
        chk("done_timeout", seen, 1);
        chk("write_count", writes_seen, n);
        if (mode == 0) chk("gapless_cycles", edges, n + 2);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("rearm_busy", busy, 1);
            chk("rearm_no_we", pixel_we, 0);
        end
        draw_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("back_to_idle", busy, 0);
    endtask

    initial begin : main
        int ax0, ay0, ax1, ay1;
        bit seen;
        rst = 1'b1;
        draw_en = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #1;
        chk("reset_outputs", {pixel_x, pixel_y, pixel_we, draw_done, busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_line(0, 0, 3, 0, 0, 1, 0);
        run_line(5, 9, 3, 2, 0, 0, 0);
        run_line(7, 7, 7, 7, 0, 1, 0);
        run_line(0, 0, 2, 2, 2, 0, 0);
        chk("stall_hold_cycles", hold11, 4);

        // Abort a line with reset while its third pixel is on the bus.
        model(0, 0, 10, 0);
        done_pending++;
        ready_mode = 0;
        @(posedge clk); #1;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd10; y1 = 8'd0;
        draw_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (pixel_we && pixel_x == 8'd2) seen = 1'b1;
        end
        chk("rst_reach_third_pixel", seen, 1);
        rst = 1'b1;
        #1;
        chk("rst_outputs_now", {pixel_x, pixel_y, pixel_we, draw_done, busy}, 0);
        exp_q.delete();
        done_pending = 0;
        draw_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_stays_idle", busy, 0);
        run_line(4, 5, 6, 5, 0, 1, 0);

        run_line(1, 1, 5, 3, 0, 0, 5);
        run_line(9, 9, 0, 0, 0, 1, 0);
        run_line(255, 0, 0, 255, 0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            if (t % 2 == 0) begin
                ax0 = $urandom_range(0, 15); ay0 = $urandom_range(0, 15);
                ax1 = $urandom_range(0, 15); ay1 = $urandom_range(0, 15);
            end else begin
                ax0 = $urandom_range(0, 255); ay0 = $urandom_range(0, 255);
                ax1 = $urandom_range(0, 255); ay1 = $urandom_range(0, 255);
            end
            run_line(ax0, ay0, ax1, ay1, (t % 3 == 0) ? 0 : 1, 0, $urandom_range(0, 2));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("done_pulses_drained", done_pending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bresenham_line_drawer.md
BRESENHAM_LINE_DRAWER -- requirements
Module: bresenham_line_drawer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, with ports listed clock first.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 draw_en  in  1  level request from the line controller; held high until draw_done is seen.
REQ-005 x0, y0  in  8 each  line start point (unsigned).
REQ-006 x1, y1  in  8 each  line end point (unsigned).
REQ-007 mem_ready  in  1  framebuffer accepts the current pixel write this cycle.
REQ-008 pixel_x, pixel_y  out  8 each  current pixel coordinate, registered.
REQ-009 pixel_we  out  1  pixel write valid.
REQ-010 draw_done  out  1  one-cycle pulse: the line is complete.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, INIT, PLOT, DONE and REARM.
REQ-013 IDLE: when draw_en=1, SHALL latch x0/y0/x1/y1 and go to INIT; inputs SHALL be ignored after this latch.
REQ-014 INIT (1 cycle): SHALL compute dx=|x1-x0| (9b unsigned), dy=-|y1-y0| (10b signed), sx/sy=+1 if end>=start else -1, err=dx+dy (11b signed), cur=(x0,y0), then go to PLOT.
REQ-015 PLOT: SHALL drive pixel_we=1 with pixel_x/pixel_y=cur.
REQ-016 PLOT, mem_ready=0: pixel_we, cur and err SHALL hold unchanged (stall).
REQ-017 PLOT, mem_ready=1 and cur==(x1,y1): SHALL go to DONE.
REQ-018 PLOT, mem_ready=1 otherwise: SHALL set e2=2*err (12b signed); if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy (both updates may occur in the same cycle).
REQ-019 SHALL emit exactly max(dx,|dy|)+1 pixel writes per line, at most one per cycle, with no gap while mem_ready=1; all octants SHALL be supported.
REQ-020 Latency: first pixel_we SHALL occur 2 cycles after draw_en is sampled high in IDLE.
REQ-021 Degenerate line (x0==x1 and y0==y1): SHALL write exactly one pixel, then DONE.
REQ-022 DONE: SHALL assert draw_done=1 and pixel_we=0 for one cycle, then go to REARM.
REQ-023 REARM: SHALL remain until draw_en=0, then go to IDLE, so a held draw_en never restarts a line.
REQ-024 Coordinates SHALL never wrap: x/y stay within [min(start,end), max(start,end)].
REQ-025 pixel_x/pixel_y SHALL be 0 whenever pixel_we=0.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and pixel_x=0, pixel_y=0, pixel_we=0, draw_done=0, busy=0.
REQ-027 rst=1 SHALL clear all internal registers (latched coordinates, dx, dy, err, sx, sy) to 0.
REQ-028 rst asserted mid-line SHALL abort the line: no further pixel_we and no draw_done are produced for it.

Structure
REQ-029 State enum, COORD_W=8 and ERR_W=11 SHALL live in shared package gpu_pkg.
REQ-030 The error/step update SHALL be a combinational sub-module bresenham_step (inputs err, dx, dy; outputs next err, step_x, step_y).

Verification
REQ-031 Horizontal line (0,0)->(3,0), mem_ready=1 -> writes (0,0),(1,0),(2,0),(3,0) on consecutive cycles, starting 2 cycles after draw_en; draw_done the cycle after (3,0).
REQ-032 Steep reversed line (5,9)->(3,2) -> exactly 8 writes, y strictly decreasing 9..2, x non-increasing, ending at (3,2).
REQ-033 Single point (7,7)->(7,7) -> exactly one write (7,7), then one draw_done pulse.
REQ-034 Line (0,0)->(2,2) with mem_ready low for 3 cycles on pixel (1,1) -> (1,1) held for 4 cycles, sequence (0,0),(1,1),(2,2) unchanged.
REQ-035 rst pulsed during the 3rd pixel of (0,0)->(10,0) -> outputs 0 immediately; no draw_done; next request starts cleanly from its own x0.
REQ-036 draw_en held high for 5 cycles after draw_done -> no second line; a new request after draw_en drops to 0 is accepted normally.
